// File: rtl/ffe_ctrl_pkg.sv
// Shared types for the FFE tap-estimator control path: host op codes,
// estimator instruction codes, sequencer states and the op-to-inst mapping.
package ffe_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP         = 2'b00,
    OP_LOAD_INIT   = 2'b01,
    OP_SHIFT_RIGHT = 2'b10,
    OP_SHIFT_LEFT  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    INST_NOP  = 3'b000,
    INST_SHR  = 3'b010,
    INST_SHL  = 3'b011,
    INST_LOAD = 3'b100
  } est_inst_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DROP  = 2'b01,
    ST_FIRE  = 2'b10,
    ST_ADAPT = 2'b11
  } seq_state_e;

  function automatic est_inst_e op_to_inst(input cmd_op_e op);
    est_inst_e r;
    case (op)
      OP_LOAD_INIT:   r = INST_LOAD;
      OP_SHIFT_RIGHT: r = INST_SHR;
      OP_SHIFT_LEFT:  r = INST_SHL;
      default:        r = INST_NOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ffe_gain_scheduler.sv
// Decaying adaptation gain: loads gain_init at window start, then steps down
// by one every gain_period cycles, never going below gain_min.
module ffe_gain_scheduler #(
  parameter int GAIN_W = 4,
  parameter int PER_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              tick,
  input  logic [GAIN_W-1:0] gain_init,
  input  logic [GAIN_W-1:0] gain_min,
  input  logic [PER_W-1:0]  gain_period,
  output logic [GAIN_W-1:0] gain
);

  logic [PER_W-1:0]  per_cnt;
  logic [PER_W-1:0]  per_cnt_nxt;
  logic [GAIN_W-1:0] gain_nxt;

  // Period counter and floored decrement; a gain already at or below the floor never moves.
  always_comb begin
    per_cnt_nxt = per_cnt;
    gain_nxt    = gain;
    if (load) begin
      per_cnt_nxt = {PER_W{1'b0}};
      gain_nxt    = gain_init;
    end else if (tick) begin
      if ((gain_period != {PER_W{1'b0}}) && (per_cnt == gain_period - PER_W'(1))) begin
        per_cnt_nxt = {PER_W{1'b0}};
        if (gain > gain_min) begin
          gain_nxt = gain - GAIN_W'(1);
        end else begin
          gain_nxt = gain;
        end
      end else begin
        per_cnt_nxt = per_cnt + PER_W'(1);
      end
    end else begin
      per_cnt_nxt = per_cnt;
    end
  end

  // Counter and gain registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= {PER_W{1'b0}};
      gain    <= {GAIN_W{1'b0}};
    end else begin
      per_cnt <= per_cnt_nxt;
      gain    <= gain_nxt;
    end
  end

endmodule

// File: rtl/ffe_adapt_sequencer.sv
// Drives the FFE tap estimator's exec_inst/inst/gain: serialises host tap
// commands and runs bounded adaptation windows. Optional cycle counter under
// FFE_ADAPT_SEQUENCER_PERF_CNT_EN.
module ffe_adapt_sequencer
  import ffe_ctrl_pkg::*;
#(
  parameter int ADAPT_BITWIDTH = 14,
  parameter int LEN_W          = 20,
  parameter int PER_W          = 16,
  parameter int FIRE_HOLD      = 2,
  localparam int GAIN_W        = $clog2(ADAPT_BITWIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  adapt_len,
  input  logic [GAIN_W-1:0] gain_init,
  input  logic [GAIN_W-1:0] gain_min,
  input  logic [PER_W-1:0]  gain_period,
  output logic              exec_inst,
  output logic [2:0]        inst,
  output logic [GAIN_W-1:0] gain,
  output logic              busy,
  output logic              done
`ifdef FFE_ADAPT_SEQUENCER_PERF_CNT_EN
  ,
  output logic [31:0]       adapt_cyc_cnt
`endif
);

  localparam logic [2:0] FIRE_LAST = 3'(FIRE_HOLD - 1);

  seq_state_e       state, state_nxt;
  cmd_op_e          op_q, op_nxt;
  logic [2:0]       fire_cnt, fire_cnt_nxt;
  logic [LEN_W-1:0] len_cnt, len_cnt_nxt;
  logic             win_start;
  logic             done_nxt;
  logic             exec_nxt;
  logic [2:0]       inst_nxt;
  logic             ready_nxt;
  logic             busy_nxt;

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_nxt    = state;
    op_nxt       = op_q;
    fire_cnt_nxt = fire_cnt;
    len_cnt_nxt  = len_cnt;
    win_start    = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_op_e'(cmd_op) != OP_NOP) begin
            op_nxt       = cmd_op_e'(cmd_op);
            fire_cnt_nxt = 3'd0;
            state_nxt    = ST_DROP;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (start) begin
          win_start   = 1'b1;
          len_cnt_nxt = {LEN_W{1'b0}};
          if (adapt_len == {LEN_W{1'b0}}) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_ADAPT;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        fire_cnt_nxt = 3'd0;
        state_nxt    = ST_FIRE;
      end
      ST_FIRE: begin
        if (fire_cnt == FIRE_LAST) begin
          fire_cnt_nxt = 3'd0;
          state_nxt    = ST_IDLE;
        end else begin
          fire_cnt_nxt = fire_cnt + 3'd1;
        end
      end
      ST_ADAPT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (len_cnt == adapt_len - LEN_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          len_cnt_nxt = len_cnt + LEN_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    exec_nxt  = !((state_nxt == ST_DROP) || (state_nxt == ST_ADAPT));
    inst_nxt  = (state_nxt == ST_FIRE) ? op_to_inst(op_nxt) : INST_NOP;
    ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt  = (state_nxt != ST_IDLE);
  end

  // State, counters and registered outputs; reset leaves the estimator heading to HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      fire_cnt  <= 3'd0;
      len_cnt   <= {LEN_W{1'b0}};
      exec_inst <= 1'b1;
      inst      <= 3'b000;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      fire_cnt  <= fire_cnt_nxt;
      len_cnt   <= len_cnt_nxt;
      exec_inst <= exec_nxt;
      inst      <= inst_nxt;
      cmd_ready <= ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  ffe_gain_scheduler #(
    .GAIN_W (GAIN_W),
    .PER_W  (PER_W)
  ) u_gain (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (win_start),
    .tick        (state == ST_ADAPT),
    .gain_init   (gain_init),
    .gain_min    (gain_min),
    .gain_period (gain_period),
    .gain        (gain)
  );

`ifdef FFE_ADAPT_SEQUENCER_PERF_CNT_EN
  // Saturating count of cycles spent adapting; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adapt_cyc_cnt <= 32'd0;
    end else if ((state == ST_ADAPT) && (adapt_cyc_cnt != 32'hFFFF_FFFF)) begin
      adapt_cyc_cnt <= adapt_cyc_cnt + 32'd1;
    end else begin
      adapt_cyc_cnt <= adapt_cyc_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_ffe_adapt_sequencer.sv
// Directed bench for ffe_adapt_sequencer: a per-cycle vector table plus
// hand-written window sequences (no-decay, abort, zero-length).
module tb_ffe_adapt_sequencer;

  localparam int GAIN_W = 4;
  localparam int LEN_W  = 20;
  localparam int PER_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic              cmd_ready;
  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  adapt_len;
  logic [GAIN_W-1:0] gain_init;
  logic [GAIN_W-1:0] gain_min;
  logic [PER_W-1:0]  gain_period;
  logic              exec_inst;
  logic [2:0]        inst;
  logic [GAIN_W-1:0] gain;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  ffe_adapt_sequencer #(
    .ADAPT_BITWIDTH (14),
    .LEN_W          (LEN_W),
    .PER_W          (PER_W),
    .FIRE_HOLD      (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ready   (cmd_ready),
    .start       (start),
    .abort       (abort),
    .adapt_len   (adapt_len),
    .gain_init   (gain_init),
    .gain_min    (gain_min),
    .gain_period (gain_period),
    .exec_inst   (exec_inst),
    .inst        (inst),
    .gain        (gain),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic       cv;
    logic [1:0] op;
    logic       st;
    logic       ab;
    logic       e_exec;
    logic [2:0] e_inst;
    logic [3:0] e_gain;
    logic       e_busy;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic cv, input logic [1:0] op, input logic st, input logic ab,
                     input logic ex, input logic [2:0] in, input logic [3:0] g,
                     input logic bs, input logic dn, input logic rd);
    vec_t v;
    v.cv = cv; v.op = op; v.st = st; v.ab = ab;
    v.e_exec = ex; v.e_inst = in; v.e_gain = g;
    v.e_busy = bs; v.e_done = dn; v.e_ready = rd;
    vq.push_back(v);
  endtask

  task automatic drive(input logic cv, input logic [1:0] op, input logic st, input logic ab);
    cmd_valid = cv;
    cmd_op    = op;
    start     = st;
    abort     = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic ex, input logic [2:0] in,
                         input logic [3:0] g, input logic bs, input logic dn, input logic rd);
    chk({tag, ".exec"},  {31'd0, exec_inst}, {31'd0, ex});
    chk({tag, ".inst"},  {29'd0, inst},      {29'd0, in});
    chk({tag, ".gain"},  {28'd0, gain},      {28'd0, g});
    chk({tag, ".busy"},  {31'd0, busy},      {31'd0, bs});
    chk({tag, ".done"},  {31'd0, done},      {31'd0, dn});
    chk({tag, ".ready"}, {31'd0, cmd_ready}, {31'd0, rd});
  endtask

  initial begin
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    adapt_len   = 20'd0;
    gain_init   = 4'd0;
    gain_min    = 4'd0;
    gain_period = 16'd0;

    repeat (2) @(negedge clk);
    chk_all("reset", 1'b1, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("post_reset", 1'b1, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1);

    // Command sequences: DROP, two FIRE cycles, back to IDLE.
    add(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b100, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b100, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b010, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b010, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b011, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b011, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1);
    // NOP is consumed without leaving IDLE.
    add(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1);
    // Window len=10, gain 9 -> 8 -> 7 floor, period 3.
    add(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 4'd9, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'd9, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'd9, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'd8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'd8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'd8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 4'd7, 1'b0, 1'b1, 1'b1);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 4'd7, 1'b0, 1'b0, 1'b1);
    // Command and start together: command first, window on the following IDLE cycle.
    add(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b011, 4'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b011, 4'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b000, 4'd7, 1'b0, 1'b0, 1'b1);
    add(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 4'd9, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3'b000, 4'd9, 1'b0, 1'b0, 1'b1);
    add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 4'd9, 1'b0, 1'b0, 1'b1);

    adapt_len   = 20'd10;
    gain_init   = 4'd9;
    gain_min    = 4'd7;
    gain_period = 16'd3;
    foreach (vq[i]) begin
      drive(vq[i].cv, vq[i].op, vq[i].st, vq[i].ab);
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].e_exec, vq[i].e_inst, vq[i].e_gain,
              vq[i].e_busy, vq[i].e_done, vq[i].e_ready);
    end

    // gain_period=0: gain holds gain_init for the whole 6-cycle window.
    adapt_len   = 20'd6;
    gain_init   = 4'd5;
    gain_min    = 4'd2;
    gain_period = 16'd0;
    drive(1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    chk_all("nodecay.c0", 1'b0, 3'b000, 4'd5, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 1; k < 6; k++) begin
      tick();
      chk_all($sformatf("nodecay.c%0d", k), 1'b0, 3'b000, 4'd5, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_all("nodecay.end", 1'b1, 3'b000, 4'd5, 1'b0, 1'b1, 1'b1);

    // Abort on the 4th cycle of a 100-cycle window: IDLE next cycle, no done.
    adapt_len   = 20'd100;
    gain_init   = 4'd6;
    gain_min    = 4'd0;
    gain_period = 16'd3;
    drive(1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    chk_all("abort.c0", 1'b0, 3'b000, 4'd6, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    chk_all("abort.c1", 1'b0, 3'b000, 4'd6, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("abort.c2", 1'b0, 3'b000, 4'd6, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("abort.c3", 1'b0, 3'b000, 4'd5, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk_all("abort.idle", 1'b1, 3'b000, 4'd5, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("abort.after%0d", k), 1'b1, 3'b000, 4'd5, 1'b0, 1'b0, 1'b1);
    end

    // Zero-length window: done pulse, exec_inst never drops.
    adapt_len = 20'd0;
    gain_init = 4'd11;
    drive(1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    chk_all("zero.done", 1'b1, 3'b000, 4'd11, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    chk_all("zero.after", 1'b1, 3'b000, 4'd11, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
